// File: rtl/led_blink_encoder_pkg.sv
// Shared definitions for the LED blink encoder.
//   blink_state_t : FSM state encoding (IDLE / ON / OFF)
//   phase_width() : width of the phase counter, sized so it can count
//                   up to max(on_ticks, off_ticks)-1 (never less than 1 bit)
package led_blink_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

  function automatic int phase_width(input int on_ticks, input int off_ticks);
    int max_ticks;
    max_ticks = (on_ticks > off_ticks) ? on_ticks : off_ticks;
    return (max_ticks <= 2) ? 1 : $clog2(max_ticks);
  endfunction

endpackage

// File: rtl/led_blink_encoder_if.sv
// Event/status bundle between control logic and the LED blink encoder.
//   evt      : event request into the encoder
//   led      : LED drive, active-high
//   busy     : encoder is mid-blink (not idle)
//   pending  : queued events not yet started
//   overflow : sticky, an event was dropped while the queue was full
// Modports: master = control logic side, slave = encoder side.
interface led_blink_encoder_if #(
  parameter int CNT_W = 4
);
  logic             evt;
  logic             led;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  modport master (
    output evt,
    input  led,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  evt,
    output led,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/led_blink_encoder_blink_tick.sv
// Free-running prescaler for the blink encoder.
// Ports:
//   sysclk : system clock
//   rst    : synchronous active-high reset
//   clr    : synchronous clear, restarts the count so a phase starts aligned
//   tick   : one-cycle pulse while the count is all-ones
//            (one tick every 2^TICK_BITS cycles)
module blink_tick #(
  parameter int TICK_BITS = 16
) (
  input  logic sysclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [TICK_BITS-1:0] count_reg;

  always_ff @(posedge sysclk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = &count_reg;

endmodule

// File: rtl/led_blink_encoder.sv
// LED blink encoder: turns single-cycle event pulses into visible blinks,
// one blink per event, queueing events that arrive mid-blink in a
// saturating pending counter.
// Ports:
//   sysclk : system clock
//   rst    : synchronous active-high reset (aborts a blink, drops the queue)
//   bus    : led_blink_encoder_if.slave (evt in; led, busy, pending,
//            overflow out)
// Build option: define EVT_EDGE_EN to count only rising edges of evt
// (registered, one extra cycle of latency); otherwise every high cycle of
// evt is one event.
module led_blink_encoder
  import led_blink_encoder_pkg::*;
#(
  parameter int TICK_BITS = 16,
  parameter int ON_TICKS  = 8,
  parameter int OFF_TICKS = 8,
  parameter int CNT_W     = 4
) (
  input  logic                  sysclk,
  input  logic                  rst,
  led_blink_encoder_if.slave    bus
);

  localparam int PHASE_W = phase_width(ON_TICKS, OFF_TICKS);
  localparam logic [PHASE_W-1:0] ON_LAST  = PHASE_W'(ON_TICKS - 1);
  localparam logic [PHASE_W-1:0] OFF_LAST = PHASE_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  blink_state_t       state_reg, state_next;
  logic [PHASE_W-1:0] phase_reg, phase_next;
  logic [CNT_W-1:0]   pending_reg, pending_next;
  logic               overflow_reg, overflow_next;
  logic               led_reg;
  logic               busy_reg;
  logic               tick;
  logic               tick_clr;
  logic               evt_inc;
  logic               evt_dec;

  // ---------------------------------------------------------------- events
`ifdef EVT_EDGE_EN
  logic evt_reg;
  logic evt_prev_reg;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      evt_reg      <= 1'b0;
      evt_prev_reg <= 1'b0;
    end else begin
      evt_reg      <= bus.evt;
      evt_prev_reg <= evt_reg;
    end
  end

  assign evt_inc = evt_reg & ~evt_prev_reg;
`else
  assign evt_inc = bus.evt;
`endif

  // ------------------------------------------------------------- prescaler
  blink_tick #(
    .TICK_BITS (TICK_BITS)
  ) u_blink_tick (
    .sysclk (sysclk),
    .rst    (rst),
    .clr    (tick_clr),
    .tick   (tick)
  );

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      led_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      // Outputs decoded from the next state so they change on the same
      // edge as the state register and come straight from flops.
      led_reg   <= (state_next == ON);
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    tick_clr   = 1'b0;
    evt_dec    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pending_reg != '0) begin
          state_next = ON;
          phase_next = '0;
          tick_clr   = 1'b1;
          evt_dec    = 1'b1;
        end
      end
      ON: begin
        if (tick) begin
          if (phase_reg == ON_LAST) begin
            state_next = OFF;
            phase_next = '0;
            tick_clr   = 1'b1;
          end else begin
            phase_next = phase_reg + 1'b1;
          end
        end
      end
      OFF: begin
        if (tick) begin
          if (phase_reg == OFF_LAST) begin
            state_next = IDLE;
            phase_next = '0;
          end else begin
            phase_next = phase_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  // ------------------------------------------------------- pending counter
  always_comb begin
    pending_next  = pending_reg;
    overflow_next = overflow_reg;
    unique case ({evt_inc, evt_dec})
      2'b10: begin
        if (pending_reg == CNT_MAX) begin
          overflow_next = 1'b1;
        end else begin
          pending_next = pending_reg + 1'b1;
        end
      end
      2'b01:   pending_next = pending_reg - 1'b1;
      default: pending_next = pending_reg;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.led      = led_reg;
  assign bus.busy     = busy_reg;
  assign bus.pending  = pending_reg;
  assign bus.overflow = overflow_reg;

endmodule
